// File: rtl/uart_rx_buffer_if.sv
// Handshake bundle between a UART receiver/consumer and uart_rx_buffer.
// master = receiver + consumer side, slave = the buffer.
interface uart_rx_buffer_if #(
    parameter int unsigned AW = 4
);
    logic          rx_rdy;
    logic [7:0]    rx_data;
    logic          rx_rdy_clr;
    logic          rd_en;
    logic [7:0]    rd_data;
    logic          empty;
    logic          full;
    logic [AW:0]   count;
    logic          overrun;
    logic          ovr_clr;

    modport master (
        output rx_rdy, rx_data, rd_en, ovr_clr,
        input  rx_rdy_clr, rd_data, empty, full, count, overrun
    );

    modport slave (
        input  rx_rdy, rx_data, rd_en, ovr_clr,
        output rx_rdy_clr, rd_data, empty, full, count, overrun
    );
endinterface

// File: rtl/uart_rx_buffer.sv
// Captures bytes from a level-flag UART receiver into a show-ahead FIFO,
// releasing the receiver flag once per byte and flagging dropped bytes.
module uart_rx_buffer #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    uart_rx_buffer_if.slave  bus
);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLR  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic           clr_q;
    logic           push_req;

    logic [7:0]     mem [DEPTH];
    logic [AW-1:0]  wr_ptr_q;
    logic [AW-1:0]  rd_ptr_q;
    logic [CW-1:0]  count_q;
    logic           ovr_q;

    logic           empty_c;
    logic           full_c;
    logic           pop_ok;
    logic           push_ok;
    logic           drop;

    // Capture FSM: one push per receiver byte, then hold off until the flag drops
    always_comb begin
        state_d  = state_q;
        push_req = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.rx_rdy) begin
                    push_req = 1'b1;
                    state_d  = CLR;
                end
            end
            CLR:     state_d = WAIT;
            WAIT:    if (!bus.rx_rdy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            clr_q   <= (state_d == CLR);
        end
    end

    assign empty_c = (count_q == CW'(0));
    assign full_c  = (count_q == CW'(DEPTH));
    assign pop_ok  = bus.rd_en && !empty_c;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign push_ok = push_req && (!full_c || pop_ok);
    assign drop    = push_req && full_c && !pop_ok;

    // Storage needs no reset; it is only observed when non-empty
    always_ff @(posedge clk) begin
        if (rst && push_ok) begin
            mem[wr_ptr_q] <= bus.rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky drop flag; a new drop beats a simultaneous clear
    always_ff @(posedge clk) begin
        if (!rst) begin
            ovr_q <= 1'b0;
        end else if (drop) begin
            ovr_q <= 1'b1;
        end else if (bus.ovr_clr) begin
            ovr_q <= 1'b0;
        end
    end

    assign bus.rx_rdy_clr = clr_q;
    assign bus.empty      = empty_c;
    assign bus.full       = full_c;
    assign bus.count      = count_q;
    assign bus.overrun    = ovr_q;
    assign bus.rd_data    = empty_c ? 8'h00 : mem[rd_ptr_q];
endmodule

// File: tb/tb_uart_rx_buffer.sv
// Scoreboard bench for uart_rx_buffer: a receiver model offers bytes, a
// queue-based FIFO model predicts occupancy/overrun, a monitor checks pops.
module tb_uart_rx_buffer;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;

    logic clk;
    logic rst;

    uart_rx_buffer_if #(.AW(AW)) bus ();

    uart_rx_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_chk  = 0;
    int         n_fail = 0;
    logic [7:0] scb [$];
    int         m_cnt  = 0;
    logic       m_ovr  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic rd_pick(input int mode);
        case (mode)
            1:       return 1'b1;
            2:       return 1'(($urandom % 2) == 0);
            3:       return 1'(($urandom % 8) == 0);
            default: return 1'b0;
        endcase
    endfunction

    // One clock: apply controls, predict the edge with the FIFO model, then check
    task automatic cycle(input logic cap, input logic rd, input logic oc, input logic rs_n = 1'b1);
        logic pop_ok;
        logic drop;
        int   acc;
        rst         = rs_n;
        bus.rd_en   = rd;
        bus.ovr_clr = oc;
        if (!rs_n) begin
            m_cnt = 0;
            m_ovr = 1'b0;
            scb.delete();
        end else begin
            pop_ok = rd && (m_cnt > 0);
            acc    = 0;
            drop   = 1'b0;
            if (cap) begin
                if (m_cnt < DEPTH || pop_ok) begin
                    acc = 1;
                    scb.push_back(bus.rx_data);
                end else begin
                    drop = 1'b1;
                end
            end
            m_cnt = m_cnt + acc - (pop_ok ? 1 : 0);
            if (drop)    m_ovr = 1'b1;
            else if (oc) m_ovr = 1'b0;
        end
        @(negedge clk);
        chk("count",      32'(bus.count),      32'(m_cnt));
        chk("empty",      32'(bus.empty),      32'(m_cnt == 0));
        chk("full",       32'(bus.full),       32'(m_cnt == DEPTH));
        chk("overrun",    32'(bus.overrun),    32'(m_ovr));
        chk("rx_rdy_clr", 32'(bus.rx_rdy_clr), 32'(cap && rs_n));
        if (m_cnt == 0) chk("rd_data_empty", 32'(bus.rd_data), 32'h0);
    endtask

    // Receiver: raise flag with byte, drop it once the clear is seen, allow return to idle
    task automatic send_byte(input logic [7:0] b, input int rmode, input logic oc_cap);
        bus.rx_rdy  = 1'b1;
        bus.rx_data = b;
        cycle(1'b1, rd_pick(rmode), oc_cap);
        bus.rx_rdy  = 1'b0;
        bus.rx_data = 8'($urandom);
        cycle(1'b0, rd_pick(rmode), 1'b0);
        cycle(1'b0, rd_pick(rmode), 1'b0);
    endtask

    task automatic drain();
        bus.rx_rdy = 1'b0;
        for (int i = 0; i < 300 && m_cnt > 0; i++) cycle(1'b0, 1'b1, 1'b0);
        chk("drain_empty", 32'(bus.empty), 32'h1);
    endtask

    // Monitor: every accepted pop must present the oldest expected byte
    initial begin
        logic [7:0] exp;
        forever begin
            @(negedge clk);
            #2;
            if (rst && bus.rd_en && !bus.empty) begin
                if (scb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL pop_data: got %0h expected nothing (scoreboard empty)", bus.rd_data);
                end else begin
                    exp = scb.pop_front();
                    chk("pop_data", 32'(bus.rd_data), 32'(exp));
                end
            end
        end
    end

    initial begin
        rst         = 1'b0;
        bus.rx_rdy  = 1'b0;
        bus.rx_data = 8'h00;
        bus.rd_en   = 1'b0;
        bus.ovr_clr = 1'b0;
        @(negedge clk);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);

        // Single byte
        send_byte(8'hA5, 0, 1'b0);
        chk("single_rd_data", 32'(bus.rd_data), 32'hA5);
        drain();

        // Fill past capacity, then drain in order
        for (int i = 0; i < 17; i++) send_byte(8'(i), 0, 1'b0);
        chk("fill_full", 32'(bus.full), 32'h1);
        chk("fill_ovr",  32'(bus.overrun), 32'h1);
        drain();
        cycle(1'b0, 1'b0, 1'b1);

        // Full FIFO with push and pop on the same edge
        for (int i = 0; i < 16; i++) send_byte(8'(i), 0, 1'b0);
        bus.rx_rdy  = 1'b1;
        bus.rx_data = 8'h55;
        cycle(1'b1, 1'b1, 1'b0);
        bus.rx_rdy  = 1'b0;
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        chk("full_pp_ovr", 32'(bus.overrun), 32'h0);
        drain();

        // Drop coinciding with clear keeps overrun, then a lone clear releases it
        for (int i = 0; i < 17; i++) send_byte(8'($urandom), 0, 1'b0);
        send_byte(8'hEE, 0, 1'b1);
        chk("ovr_set_wins", 32'(bus.overrun), 32'h1);
        cycle(1'b0, 1'b0, 1'b1);
        chk("ovr_cleared", 32'(bus.overrun), 32'h0);
        drain();

        // Streaming through pointer wrap
        for (int i = 0; i < 40; i++) begin
            send_byte(8'($urandom), 1, 1'b0);
            chk("stream_cnt_le2", 32'(bus.count <= 2), 32'h1);
        end
        drain();

        // Reset while in CLR with bytes stored, receiver flag still high
        for (int i = 0; i < 5; i++) send_byte(8'($urandom), 0, 1'b0);
        bus.rx_rdy  = 1'b1;
        bus.rx_data = 8'h3C;
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        bus.rx_rdy = 1'b0;
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        chk("rst_one_capture", 32'(bus.count), 32'h1);
        drain();

        // Randomized traffic
        for (int i = 0; i < 200; i++) begin
            send_byte(8'($urandom), int'($urandom % 4), 1'(($urandom % 4) == 0));
            if (($urandom % 3) == 0)
                cycle(1'b0, rd_pick(2), 1'(($urandom % 4) == 0));
        end
        drain();
        cycle(1'b0, 1'b0, 1'b0);
        chk("scb_empty", 32'(scb.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
